// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file types for the write-back queue
package regfile_pkg;

    localparam int NLOC  = 32;
    localparam int DBITS = 32;

    typedef logic [$clog2(NLOC)-1:0] reg_addr_t;
    typedef logic [DBITS-1:0]        reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-match lookup of one address across pending queue entries
module wb_fwd_match #(
    parameter int Depth = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic [AW-1:0]            addr_arr [Depth],
    input  logic [DW-1:0]            data_arr [Depth],
    input  logic [Depth-1:0]         valid,
    input  logic [$clog2(Depth)-1:0] head,
    input  logic [AW-1:0]            lookup,
    output logic                     hit,
    output logic [DW-1:0]            data
);

    localparam int PW = $clog2(Depth);

    logic [PW-1:0] idx;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < Depth; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && (addr_arr[idx] == lookup) && (lookup != '0)) begin
                hit  = 1'b1;
                data = data_arr[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - in-order write-back buffer draining onto the register file write port
module regfile_write_queue
    import regfile_pkg::*;
#(
    parameter int Nloc  = NLOC,
    parameter int Dbits = DBITS,
    parameter int Depth = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$clog2(Nloc)-1:0]    in_addr,
    input  logic [Dbits-1:0]           in_data,
    input  logic                       drain_hold,
    output logic                       Werf,
    output logic [$clog2(Nloc)-1:0]    WriteAddr,
    output logic [Dbits-1:0]           WriteData,
    input  logic [$clog2(Nloc)-1:0]    ReadAddr1,
    input  logic [$clog2(Nloc)-1:0]    ReadAddr2,
    output logic                       fwd_hit1,
    output logic [Dbits-1:0]           fwd_data1,
    output logic                       fwd_hit2,
    output logic [Dbits-1:0]           fwd_data2,
    output logic [$clog2(Depth):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(Nloc);
    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q [Depth];
    logic [AW-1:0]    addr_d [Depth];
    logic [Dbits-1:0] data_q [Depth];
    logic [Dbits-1:0] data_d [Depth];
    logic [Depth-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic push;
    logic alloc;

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign in_ready  = (count_q < CW'(Depth));
    assign Werf      = !empty && !drain_hold;
    assign WriteAddr = empty ? '0 : addr_q[head_q];
    assign WriteData = empty ? '0 : data_q[head_q];

    // Register 0 is hard-wired, so an accepted write to it never takes a slot.
    assign push  = in_valid && in_ready;
    assign alloc = push && (in_addr != '0);

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (alloc) begin
            addr_d[tail_q]  = in_addr;
            data_d[tail_q]  = in_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        if (Werf) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        count_d = count_q + CW'(alloc) - CW'(Werf);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < Depth; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    wb_fwd_match #(.Depth(Depth), .AW(AW), .DW(Dbits)) u_fwd1 (
        .addr_arr (addr_q),
        .data_arr (data_q),
        .valid    (valid_q),
        .head     (head_q),
        .lookup   (ReadAddr1),
        .hit      (fwd_hit1),
        .data     (fwd_data1)
    );

    wb_fwd_match #(.Depth(Depth), .AW(AW), .DW(Dbits)) u_fwd2 (
        .addr_arr (addr_q),
        .data_arr (data_q),
        .valid    (valid_q),
        .head     (head_q),
        .lookup   (ReadAddr2),
        .hit      (fwd_hit2),
        .data     (fwd_data2)
    );

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - directed self-checking bench for regfile_write_queue
module tb_regfile_write_queue;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_hold;
    logic        Werf;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic [4:0]  ReadAddr1;
    logic [4:0]  ReadAddr2;
    logic        fwd_hit1;
    logic [31:0] fwd_data1;
    logic        fwd_hit2;
    logic [31:0] fwd_data2;
    logic [2:0]  count;
    logic        empty;

    int n_cmp = 0;
    int n_err = 0;

    regfile_write_queue dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .drain_hold (drain_hold),
        .Werf       (Werf),
        .WriteAddr  (WriteAddr),
        .WriteData  (WriteData),
        .ReadAddr1  (ReadAddr1),
        .ReadAddr2  (ReadAddr2),
        .fwd_hit1   (fwd_hit1),
        .fwd_data1  (fwd_data1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data2  (fwd_data2),
        .count      (count),
        .empty      (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic push_set(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_addr    = '0;
        in_data    = '0;
        drain_hold = 1'b0;
        ReadAddr1  = '0;
        ReadAddr2  = '0;
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_werf", 32'(Werf), 32'd0);
        chk("rst_waddr", 32'(WriteAddr), 32'd0);
        chk("rst_wdata", WriteData, 32'd0);
        chk("rst_hit1", 32'(fwd_hit1), 32'd0);
        chk("rst_hit2", 32'(fwd_hit2), 32'd0);
        chk("rst_fdata1", fwd_data1, 32'd0);
        chk("rst_fdata2", fwd_data2, 32'd0);
        tick();
        reset_n = 1'b1;

        // Single push, one-cycle latency to the write port, then drained
        push_set(5'd5, 32'hDEADBEEF);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t1_werf", 32'(Werf), 32'd1);
        chk("t1_waddr", 32'(WriteAddr), 32'd5);
        chk("t1_wdata", WriteData, 32'hDEADBEEF);
        chk("t1_count", 32'(count), 32'd1);
        tick();
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_werf_off", 32'(Werf), 32'd0);

        // Incoming request is not forwarded; it is once accepted, even as head being written
        ReadAddr1 = 5'd7;
        push_set(5'd7, 32'hA);
        #1;
        chk("t6_hit_pre", 32'(fwd_hit1), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t6_hit_post", 32'(fwd_hit1), 32'd1);
        chk("t6_data_post", fwd_data1, 32'hA);
        chk("t6_werf", 32'(Werf), 32'd1);
        tick();
        chk("t6_hit_gone", 32'(fwd_hit1), 32'd0);

        // Duplicate destination: forward youngest, drain in order
        drain_hold = 1'b1;
        ReadAddr1  = 5'd3;
        push_set(5'd3, 32'h11); tick();
        push_set(5'd3, 32'h22); tick();
        push_set(5'd3, 32'h33); tick();
        in_valid = 1'b0;
        #1;
        chk("t2_hit1", 32'(fwd_hit1), 32'd1);
        chk("t2_fdata1", fwd_data1, 32'h33);
        chk("t2_count", 32'(count), 32'd3);
        chk("t2_werf_held", 32'(Werf), 32'd0);
        drain_hold = 1'b0;
        #1;
        chk("t2_w0_en", 32'(Werf), 32'd1);
        chk("t2_w0", WriteData, 32'h11);
        tick();
        chk("t2_w1", WriteData, 32'h22);
        chk("t2_w1_addr", 32'(WriteAddr), 32'd3);
        tick();
        chk("t2_w2", WriteData, 32'h33);
        tick();
        chk("t2_empty", 32'(empty), 32'd1);

        // Register 0 writes are accepted and dropped
        ReadAddr2 = 5'd0;
        push_set(5'd0, 32'hFFFFFFFF);
        #1;
        chk("t3_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t3_count", 32'(count), 32'd0);
        chk("t3_werf", 32'(Werf), 32'd0);
        chk("t3_hit2", 32'(fwd_hit2), 32'd0);

        // Fill under hold, reject a fifth, then stream through the wrap
        drain_hold = 1'b1;
        push_set(5'd1, 32'h101); tick();
        push_set(5'd2, 32'h102); tick();
        push_set(5'd3, 32'h103); tick();
        push_set(5'd4, 32'h104); tick();
        chk("t4_full_count", 32'(count), 32'd4);
        chk("t4_full_ready", 32'(in_ready), 32'd0);
        push_set(5'd9, 32'h999);
        tick();
        chk("t4_reject_count", 32'(count), 32'd4);
        ReadAddr2 = 5'd9;
        #1;
        chk("t4_reject_fwd", 32'(fwd_hit2), 32'd0);
        drain_hold = 1'b0;
        push_set(5'd10, 32'h10A);
        #1;
        chk("t4_a_addr", 32'(WriteAddr), 32'd1);
        chk("t4_a_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t4_b_count", 32'(count), 32'd3);
        chk("t4_b_ready", 32'(in_ready), 32'd1);
        chk("t4_b_addr", 32'(WriteAddr), 32'd2);
        tick();
        push_set(5'd11, 32'h10B);
        #1;
        chk("t4_c_addr", 32'(WriteAddr), 32'd3);
        chk("t4_c_count", 32'(count), 32'd3);
        tick();
        push_set(5'd12, 32'h10C);
        #1;
        chk("t4_d_addr", 32'(WriteAddr), 32'd4);
        chk("t4_d_data", WriteData, 32'h104);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t4_e_addr", 32'(WriteAddr), 32'd10);
        chk("t4_e_data", WriteData, 32'h10A);
        chk("t4_e_count", 32'(count), 32'd3);
        tick();
        chk("t4_f_addr", 32'(WriteAddr), 32'd11);
        chk("t4_f_count", 32'(count), 32'd2);
        tick();
        chk("t4_g_addr", 32'(WriteAddr), 32'd12);
        chk("t4_g_data", WriteData, 32'h10C);
        tick();
        chk("t4_empty", 32'(empty), 32'd1);

        // Asynchronous reset discards pending entries without writing them
        drain_hold = 1'b1;
        push_set(5'd20, 32'h20); tick();
        push_set(5'd21, 32'h21); tick();
        in_valid   = 1'b0;
        drain_hold = 1'b0;
        #1;
        chk("t5_pre_count", 32'(count), 32'd2);
        chk("t5_pre_werf", 32'(Werf), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_werf", 32'(Werf), 32'd0);
        chk("t5_count", 32'(count), 32'd0);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_write", 32'(Werf), 32'd0);
        end
        chk("t5_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
